ram_16x8: RTL and testbench

RAM_16X8 -- requirements
Module: ram_16x8

---
 rtl/ram_pkg.sv | 8 +
 rtl/ram_16x8.sv | 37 +++
 tb/tb_ram_16x8.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared size defaults for the 16x8 flip-flop RAM.
package ram_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

endpackage : ram_pkg

// File: rtl/ram_16x8.sv
// Single-port flip-flop RAM with registered, read-first output and
// synchronous active-low clear of both the array and the output register.
module ram_16x8
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  // Array and read register share one process: the read samples the
  // pre-edge word, so a same-address write is read-first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      dout_q <= '0;
    end else begin
      dout_q <= mem_q[addr];
      if (we) begin
        mem_q[addr] <= din;
      end
    end
  end

  assign dout = dout_q;

endmodule : ram_16x8

// File: tb/tb_ram_16x8.sv
// Self-checking bench for ram_16x8: a reference array produces the expected
// read word at drive time; it is queued and compared one edge later.
module tb_ram_16x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  logic [7:0] model [16];
  logic [7:0] sb [$];
  logic [7:0] exp_v;
  int         n_pass  = 0;
  int         n_total = 0;

  ram_16x8 #(
    .DATA_W(8),
    .ADDR_W(4),
    .DEPTH (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  // Drive one edge; push the expected dout for that edge, update the model,
  // then return 1 time unit after the edge so outputs are stable.
  task automatic step(input logic r, input logic w, input logic [3:0] a,
                      input logic [7:0] d);
    rst_n = r;
    we    = w;
    addr  = a;
    din   = d;
    if (!r) begin
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      sb.push_back(8'h00);
    end else begin
      sb.push_back(model[a]);
      if (w) model[a] = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 4'h7, 8'h3C);
    exp_v = sb.pop_front();
    n_total++;
    if (dout !== exp_v) $display("FAIL reset_dout: dout=%h expected=%h", dout, exp_v);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i), 8'h00);
      exp_v = sb.pop_front();
      n_total++;
      if (dout !== exp_v || dout !== 8'h00)
        $display("FAIL reset_read[%0d]: dout=%h expected=%h", i, dout, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic       w [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] a [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    logic [7:0] d [4] = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[i], a[i], d[i]);
      exp_v = sb.pop_front();
      n_total++;
      if (dout !== exp_v) $display("FAIL write_read[%0d]: dout=%h expected=%h", i, dout, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_read_during_write();
    logic       w [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] d [3] = '{8'h11, 8'h22, 8'h00};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, w[i], 4'd3, d[i]);
      exp_v = sb.pop_front();
      n_total++;
      if (dout !== exp_v) $display("FAIL rdw[%0d]: dout=%h expected=%h", i, dout, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_boundary();
    logic       w [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] a [5] = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd14};
    logic [7:0] d [5] = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, w[i], a[i], d[i]);
      exp_v = sb.pop_front();
      n_total++;
      if (dout !== exp_v) $display("FAIL boundary[%0d]: dout=%h expected=%h", i, dout, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic       r [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       w [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] a [5] = '{4'd5, 4'd5, 4'd5, 4'd6, 4'd6};
    logic [7:0] d [5] = '{8'hC3, 8'h00, 8'h77, 8'h9E, 8'h00};
    for (int i = 0; i < 5; i++) begin
      step(r[i], w[i], a[i], d[i]);
      exp_v = sb.pop_front();
      n_total++;
      if (dout !== exp_v) $display("FAIL reset_mid[%0d]: dout=%h expected=%h", i, dout, exp_v);
      else n_pass++;
    end
    step(1'b1, 1'b0, 4'd5, 8'h00);
    exp_v = sb.pop_front();
    n_total++;
    if (dout !== 8'h00) $display("FAIL reset_mid_addr5: dout=%h expected=00", dout);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)));
      exp_v = sb.pop_front();
      n_total++;
      if (dout !== exp_v) $display("FAIL random[%0d]: dout=%h expected=%h", i, dout, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    test_reset();
    test_write_read();
    test_read_during_write();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ram_16x8
